// File: rtl/pin_input_conditioner_pkg.sv
// Shared constants and the counter-width helper for the pin input conditioner.
package pin_cond_pkg;

  localparam int PIN_COND_NUM_PINS     = 9;
  localparam int PIN_COND_DEF_DEBOUNCE = 16;

  // Counter holds 0..n-1, so ceil(log2(n)) bits suffice.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pin_input_conditioner_if.sv
// Pin-level bundle between the pad side and the conditioner.
// Edge-capture signals exist only when PIN_EDGE_CAPTURE_EN is defined.
interface pin_input_conditioner_if
  import pin_cond_pkg::*;
#(
  parameter int NUM_PINS = PIN_COND_NUM_PINS
);
  logic [NUM_PINS-1:0] pin_raw;
  logic [NUM_PINS-1:0] pin_clean;
  logic [NUM_PINS-1:0] change_mask;
  logic                pin_changed;
  logic                settled;
`ifdef PIN_EDGE_CAPTURE_EN
  logic [NUM_PINS-1:0] edge_clr;
  logic [NUM_PINS-1:0] edge_sticky;
`endif

  modport master (
    output pin_raw,
`ifdef PIN_EDGE_CAPTURE_EN
    output edge_clr,
    input  edge_sticky,
`endif
    input  pin_clean,
    input  change_mask,
    input  pin_changed,
    input  settled
  );

  modport slave (
    input  pin_raw,
`ifdef PIN_EDGE_CAPTURE_EN
    input  edge_clr,
    output edge_sticky,
`endif
    output pin_clean,
    output change_mask,
    output pin_changed,
    output settled
  );

endinterface

// File: rtl/pin_input_conditioner_debounce_cell.sv
// One pin: synchroniser chain, stability counter, clean level and change strobe.
module debounce_cell
  import pin_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = PIN_COND_DEF_DEBOUNCE,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_raw_i,
  output logic pin_clean_o,
  output logic change_o,
  output logic change_d_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   change_q, change_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw_i};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Any agreement with the clean level discards the partial count.
  always_comb begin
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    change_d = 1'b0;
    if (sync_bit == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      clean_d  = sync_bit;
      cnt_d    = '0;
      change_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      change_q <= change_d;
    end
  end

  assign pin_clean_o = clean_q;
  assign change_o    = change_q;
  assign change_d_o  = change_d;
  assign busy_o      = (cnt_q != '0);

endmodule

// File: rtl/pin_input_conditioner.sv
// Synchronises and debounces NUM_PINS pad inputs; flags changes and quiescence.
// Optional sticky edge capture is built when PIN_EDGE_CAPTURE_EN is defined.
module pin_input_conditioner
  import pin_cond_pkg::*;
#(
  parameter int NUM_PINS        = PIN_COND_NUM_PINS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = PIN_COND_DEF_DEBOUNCE
) (
  input  logic                      clk,
  input  logic                      rst,
  pin_input_conditioner_if.slave    cond_if
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [NUM_PINS-1:0] clean_vec;
  logic [NUM_PINS-1:0] change_vec;
  logic [NUM_PINS-1:0] change_d_vec;
  logic [NUM_PINS-1:0] busy_vec;
  logic                pin_changed_q;
  logic                settled_q;

  generate
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      debounce_cell #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_cell (
        .clk         (clk),
        .rst         (rst),
        .pin_raw_i   (cond_if.pin_raw[gi]),
        .pin_clean_o (clean_vec[gi]),
        .change_o    (change_vec[gi]),
        .change_d_o  (change_d_vec[gi]),
        .busy_o      (busy_vec[gi])
      );
    end
  endgenerate

  // pin_changed is built from next-state strobes so it lines up with change_mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_changed_q <= 1'b0;
      settled_q     <= 1'b1;
    end else begin
      pin_changed_q <= |change_d_vec;
      settled_q     <= ~|busy_vec;
    end
  end

  assign cond_if.pin_clean   = clean_vec;
  assign cond_if.change_mask = change_vec;
  assign cond_if.pin_changed = pin_changed_q;
  assign cond_if.settled     = settled_q;

`ifdef PIN_EDGE_CAPTURE_EN
  logic [NUM_PINS-1:0] sticky_q, sticky_d;

  // A fresh change outranks a coincident clear.
  always_comb begin
    sticky_d = (sticky_q & ~cond_if.edge_clr) | change_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign cond_if.edge_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pin_input_conditioner;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [8:0] cmask_seen;
  logic [8:0] clean_seen;
  logic       unsettled_seen;
  int         cmask_pulses;
  int         changed_pulses;

  pin_input_conditioner_if #(.NUM_PINS(9)) pif ();

  pin_input_conditioner #(
    .NUM_PINS        (9),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cond_if (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cmask_seen     = '0;
    clean_seen     = '0;
    unsettled_seen = 1'b0;
    cmask_pulses   = 0;
    changed_pulses = 0;
  endtask

  task automatic tick_mon();
    tick();
    cmask_seen = cmask_seen | pif.change_mask;
    clean_seen = clean_seen | pif.pin_clean;
    if (!pif.settled) unsettled_seen = 1'b1;
    if (pif.change_mask != '0) cmask_pulses++;
    if (pif.pin_changed) changed_pulses++;
  endtask

  task automatic go_idle(input string tag);
    pif.pin_raw = '0;
    repeat (10) tick();
    check_eq({tag, "_idle_clean"}, 16'(pif.pin_clean), 16'h000);
    check_eq({tag, "_idle_settled"}, 16'(pif.settled), 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    pif.pin_raw = 9'h1FF;
`ifdef PIN_EDGE_CAPTURE_EN
    pif.edge_clr = '0;
`endif
    clear_mon();

    // Reset with all pins high, then power-on transition after release
    repeat (3) tick();
    check_eq("rst_clean",   16'(pif.pin_clean),   16'h000);
    check_eq("rst_settled", 16'(pif.settled),     16'h1);
    check_eq("rst_cmask",   16'(pif.change_mask), 16'h000);
    check_eq("rst_changed", 16'(pif.pin_changed), 16'h0);
    rst = 1'b0;
    repeat (4) tick();
    check_eq("por_settled_busy", 16'(pif.settled), 16'h0);
    tick();
    check_eq("por_clean_pre", 16'(pif.pin_clean), 16'h000);
    tick();
    check_eq("por_clean",   16'(pif.pin_clean),   16'h1FF);
    check_eq("por_cmask",   16'(pif.change_mask), 16'h1FF);
    check_eq("por_changed", 16'(pif.pin_changed), 16'h1);
    tick();
    check_eq("por_cmask_off",   16'(pif.change_mask), 16'h000);
    check_eq("por_changed_off", 16'(pif.pin_changed), 16'h0);
    check_eq("por_settled",     16'(pif.settled),     16'h1);
    go_idle("por");

    // Three-cycle glitch on pin 2 is rejected
    clear_mon();
    pif.pin_raw[2] = 1'b1;
    repeat (3) tick_mon();
    pif.pin_raw[2] = 1'b0;
    repeat (10) tick_mon();
    check_eq("glitch_clean",     16'(clean_seen),     16'h000);
    check_eq("glitch_cmask",     16'(cmask_seen),     16'h000);
    check_eq("glitch_unsettled", 16'(unsettled_seen), 16'h1);
    check_eq("glitch_settled",   16'(pif.settled),    16'h1);

    // Pin 5 bounces once, then holds: clean follows 4 cycles after last sync edge
    clear_mon();
    pif.pin_raw[5] = 1'b1;
    repeat (2) tick_mon();
    pif.pin_raw[5] = 1'b0;
    tick_mon();
    pif.pin_raw[5] = 1'b1;
    repeat (5) tick_mon();
    check_eq("bounce_clean_pre", 16'(pif.pin_clean), 16'h000);
    tick_mon();
    check_eq("bounce_clean", 16'(pif.pin_clean),   16'h020);
    check_eq("bounce_cmask", 16'(pif.change_mask), 16'h020);
    repeat (5) tick_mon();
    check_eq("bounce_pulses", 16'(cmask_pulses), 16'd1);
    go_idle("bounce");

    // Pins 0 and 8 rise on the same edge
    clear_mon();
    pif.pin_raw = 9'h101;
    repeat (5) tick_mon();
    check_eq("dual_clean_pre", 16'(pif.pin_clean), 16'h000);
    tick_mon();
    check_eq("dual_cmask",   16'(pif.change_mask), 16'h101);
    check_eq("dual_changed", 16'(pif.pin_changed), 16'h1);
    check_eq("dual_clean",   16'(pif.pin_clean),   16'h101);
    repeat (4) tick_mon();
    check_eq("dual_changed_pulses", 16'(changed_pulses), 16'd1);
    check_eq("dual_cmask_pulses",   16'(cmask_pulses),   16'd1);

    // Asynchronous reset in the middle of a pin 3 transition
    pif.pin_raw[3] = 1'b1;
    repeat (4) tick();
    check_eq("abort_settled_pre", 16'(pif.settled), 16'h0);
    #3;
    rst = 1'b1;
    pif.pin_raw = '0;
    #1;
    check_eq("abort_clean",   16'(pif.pin_clean),   16'h000);
    check_eq("abort_settled", 16'(pif.settled),     16'h1);
    check_eq("abort_cmask",   16'(pif.change_mask), 16'h000);
    check_eq("abort_changed", 16'(pif.pin_changed), 16'h0);
    repeat (2) tick();
    rst = 1'b0;
    clear_mon();
    repeat (10) tick_mon();
    check_eq("abort_no_cmask", 16'(cmask_seen), 16'h000);
    check_eq("abort_no_clean", 16'(clean_seen), 16'h000);

`ifdef PIN_EDGE_CAPTURE_EN
    // Sticky capture on pin 4: set, set-beats-clear, then clear
    pif.pin_raw[4] = 1'b1;
    repeat (6) tick();
    check_eq("edge_cmask_rise", 16'(pif.change_mask), 16'h010);
    tick();
    check_eq("edge_sticky_set", 16'(pif.edge_sticky), 16'h010);
    pif.pin_raw[4] = 1'b0;
    repeat (6) tick();
    check_eq("edge_cmask_fall", 16'(pif.change_mask), 16'h010);
    pif.edge_clr = 9'h010;
    tick();
    check_eq("edge_sticky_set_wins", 16'(pif.edge_sticky), 16'h010);
    pif.edge_clr = 9'h000;
    tick();
    pif.edge_clr = 9'h010;
    tick();
    pif.edge_clr = 9'h000;
    check_eq("edge_sticky_cleared", 16'(pif.edge_sticky), 16'h000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pin_input_conditioner.md
Name: pin_input_conditioner

Overview:
- Upstream conditioning stage for the mux wrapper's nine input pins (data and select lines).
- Synchronises each raw pad input into the core clock domain and debounces it.
- Presents glitch-free levels to the mux, plus change-notification strobes.
- Prevents metastable or bouncing select lines from producing runt mux outputs.

Parameters:
- NUM_PINS, 9, number of conditioned input pins.
- SYNC_STAGES, 2, flip-flop stages per synchroniser; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required before the clean output follows; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES), per-pin counter width; derived, do not override.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- pin_raw  input  NUM_PINS  raw pad levels, asynchronous to clk.
- pin_clean  output  NUM_PINS  debounced, synchronised levels; feed the mux data and select inputs.
- change_mask  output  NUM_PINS  one-cycle mask of pins whose pin_clean updated this cycle.
- pin_changed  output  1  OR-reduction of change_mask; registered in the same cycle as change_mask.
- settled  output  1  high when every pin's counter is zero, i.e. no transition is pending.

Behaviour:
- Reset:
  - Asynchronous on rst rising edge; release is synchronous to clk.
  - Synchroniser flops, counters, pin_clean, change_mask and pin_changed all reset to 0.
  - settled resets to 1.
- Synchroniser:
  - SYNC_STAGES flops per pin.
  - sync_q = last stage. No logic between stages.
- Per-pin debounce, one independent instance per pin:
  - If sync_q == pin_clean: counter <= 0.
  - If sync_q != pin_clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If sync_q != pin_clean and counter == DEBOUNCE_CYCLES-1: pin_clean <= sync_q, counter <= 0, change_mask[i] <= 1 for exactly one cycle.
- Latency:
  - A clean step on pin_raw reaches pin_clean SYNC_STAGES + DEBOUNCE_CYCLES clk cycles after the first sampling edge.
  - change_mask asserts in the same cycle pin_clean updates.
- Glitch rejection:
  - Any return of sync_q to pin_clean before the count completes clears the counter.
  - No partial credit is kept. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches pin_clean.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous pins:
  - Pins are fully independent. Several bits of change_mask may assert in the same cycle.
  - pin_changed is a single pulse regardless of how many bits are set.
- settled: registered, equal to NOR of all counters' non-zero flags from the previous cycle.
- Reset mid-count: pending counts are discarded, pin_clean returns to 0, and no change_mask pulse is emitted for the aborted transition.
- After reset release, a pin held high is reported as a normal 0->1 transition with a change_mask pulse after full latency.

Optional Feature:
- Macro: PIN_EDGE_CAPTURE_EN.
- When defined, the block adds:
  - Input edge_clr (NUM_PINS), write-one-to-clear.
  - Output edge_sticky (NUM_PINS).
  - edge_sticky[i] sets on change_mask[i]. It clears when edge_clr[i]=1 unless change_mask[i] is high the same cycle; set wins.
  - edge_sticky resets to 0.
- When undefined: neither port exists and no sticky logic is generated.

Decomposition:
- Package pin_cond_pkg holds:
  - Constants PIN_COND_NUM_PINS=9 and PIN_COND_DEF_DEBOUNCE=16.
  - Function cnt_width(n) returning the CNT_W derivation.
- Sub-module debounce_cell: one pin's synchroniser, counter and clean/change registers. Generated NUM_PINS times.
- Top level holds the change OR-reduction, settled and the optional sticky register.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset with pin_raw=9'h1FF -> pin_clean=0, settled=1 during reset; 6 cycles after release pin_clean=9'h1FF, change_mask=9'h1FF for 1 cycle, pin_changed=1 for 1 cycle.
- pin_raw[2] 3-cycle high pulse from steady 0 -> pin_clean stays 9'h000, change_mask never asserts, settled drops then returns to 1.
- pin_raw[5] rises, bounces low for 1 cycle after 2 cycles, then holds high -> pin_clean[5] rises exactly 4 cycles after the last synchronised edge; one change_mask pulse.
- pin_raw[0] and pin_raw[8] step high on the same edge -> change_mask=9'h101 in one cycle, pin_changed single pulse.
- rst asserted asynchronously 2 cycles into a pin_raw[3] transition -> outputs are 0 immediately without waiting for clk; no change_mask pulse for the aborted transition.
- PIN_EDGE_CAPTURE_EN: change on pin 4 -> edge_sticky[4]=1; edge_clr=9'h010 coincident with a new change on pin 4 -> edge_sticky[4] stays 1; edge_clr alone -> clears to 0.
